mio_clkseq: RTL and testbench

Clock-change sequencer for the MIO link. Sits between the MIO configuration register block and the MIO clock divider/phase generator. When software writes a new divider or phase setting, it stops traffic cleanly before applying it:
- pauses the transmit path and waits for the TX FIFO and serializer to drain;
- gates the I/O clock for a hold period and loads the new settings;
- re-enables the clock and holds TX off until the divider output settles.

---
 rtl/mio_pkg.sv | 32 +++
 rtl/mio_clkseq_cnt.sv | 27 ++
 rtl/mio_clkseq.sv | 218 +++++++++++++++++++++
 tb/tb_mio_clkseq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO clock-change sequencer and the MIO register block.
package mio_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_STOP   = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DRAIN  = ST_DRAIN,
        S_STOP   = ST_STOP,
        S_LOAD   = ST_LOAD,
        S_SETTLE = ST_SETTLE
    } mio_state_t;

    // Default phases for a divider value: returns {clkphase1, clkphase0}.
    // Each phase is {fall, rise}; phase 1 sits a quarter period after phase 0.
    function automatic logic [31:0] def_phase(input logic [7:0] def_clk);
        logic [8:0] w_sum;
        logic [7:0] w_fall0;
        logic [7:0] w_rise1;
        logic [7:0] w_fall1;
        w_sum   = {1'b0, def_clk} + 9'd1;
        w_fall0 = w_sum[8:1];
        w_rise1 = {1'b0, w_sum[8:2]};
        w_fall1 = w_rise1 + w_fall0;
        return {w_fall1, w_rise1, w_fall0, 8'h00};
    endfunction

endpackage

// File: rtl/mio_clkseq_cnt.sv
// Saturating up-counter with synchronous clear; shared by the DRAIN/STOP/SETTLE phases.
module mio_clkseq_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Clear has priority; increment stops at all-ones so the count never wraps.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mio_clkseq.sv
// MIO clock-change sequencer: drains TX, gates the I/O clock, loads the new
// divider/phase settings, then holds TX off while the divider output settles.
//
// state  | meaning
// IDLE   | running normally, waiting for a clock change request
// DRAIN  | TX paused, waiting for FIFO and serializer to empty (or timeout)
// STOP   | I/O clock gated, counting HOLD cycles
// LOAD   | shadow settings copied to the active registers
// SETTLE | clock running again, TX held off for SETTLE cycles
//
// Output flops are a registered decode of the state, so every output lags the
// state register by one cycle; the active divider/phase pass through the same
// stage so they change exactly when clk_en returns high.
module mio_clkseq
    import mio_pkg::*;
#(
    parameter int DEF_CLK = 7,
    parameter int HOLD    = 4,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        clkchange,
    input  logic [7:0]  clkdiv_in,
    input  logic [15:0] clkphase0_in,
    input  logic [15:0] clkphase1_in,
    input  logic        tx_en,
    input  logic        tx_empty,
    input  logic        tx_idle,
    input  logic        timeout_clr,
    output logic [7:0]  clkdiv,
    output logic [15:0] clkphase0,
    output logic [15:0] clkphase1,
    output logic        clk_en,
    output logic        tx_pause,
    output logic        busy,
    output logic        timeout
);

    localparam logic [7:0]    DEF_DIV     = 8'(DEF_CLK);
    localparam logic [31:0]   DEF_PH      = def_phase(DEF_DIV);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);

    mio_state_t    r_state;
    mio_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_load;
    logic          w_to_set;
    logic          w_drained;

    logic [7:0]    r_sh_div;
    logic [15:0]   r_sh_ph0;
    logic [15:0]   r_sh_ph1;
    logic [7:0]    r_act_div;
    logic [15:0]   r_act_ph0;
    logic [15:0]   r_act_ph1;
    logic          r_pending;
    logic          r_timeout;

    logic [7:0]    r_clkdiv;
    logic [15:0]   r_clkphase0;
    logic [15:0]   r_clkphase1;
    logic          r_clk_en;
    logic          r_tx_pause;
    logic          r_busy;

    assign w_drained = (tx_empty & tx_idle) | ~tx_en;

    mio_clkseq_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk    (clk),
        .nreset (nreset),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter control and load/timeout strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_load      = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clkchange) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = S_STOP;
                    w_cnt_clr   = 1'b1;
                end else if (w_cnt == TO_LAST) begin
                    w_state_nxt = S_STOP;
                    w_cnt_clr   = 1'b1;
                    w_to_set    = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt == HOLD_LAST) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SETTLE;
                w_cnt_clr   = 1'b1;
            end
            S_SETTLE: begin
                if (w_cnt == SETTLE_LAST) begin
                    w_cnt_clr = 1'b1;
                    // A request landing on the final settle cycle still counts as pending.
                    w_state_nxt = (r_pending | clkchange) ? S_DRAIN : S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // Shadow and active settings; the load reads the shadow before a coincident request overwrites it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sh_div  <= DEF_DIV;
            r_sh_ph0  <= DEF_PH[15:0];
            r_sh_ph1  <= DEF_PH[31:16];
            r_act_div <= DEF_DIV;
            r_act_ph0 <= DEF_PH[15:0];
            r_act_ph1 <= DEF_PH[31:16];
        end else begin
            if (clkchange) begin
                r_sh_div <= clkdiv_in;
                r_sh_ph0 <= clkphase0_in;
                r_sh_ph1 <= clkphase1_in;
            end
            if (w_load) begin
                r_act_div <= r_sh_div;
                r_act_ph0 <= r_sh_ph0;
                r_act_ph1 <= r_sh_ph1;
            end
        end
    end

    // Pending request and sticky timeout; set beats clear in both.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pending <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (clkchange && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Registered output decode of the current state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_clkdiv    <= DEF_DIV;
            r_clkphase0 <= DEF_PH[15:0];
            r_clkphase1 <= DEF_PH[31:16];
            r_clk_en    <= 1'b1;
            r_tx_pause  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_clkdiv    <= r_act_div;
            r_clkphase0 <= r_act_ph0;
            r_clkphase1 <= r_act_ph1;
            r_clk_en    <= !((r_state == S_STOP) || (r_state == S_LOAD));
            r_tx_pause  <= (r_state != S_IDLE);
            r_busy      <= (r_state != S_IDLE);
        end
    end

    assign clkdiv    = r_clkdiv;
    assign clkphase0 = r_clkphase0;
    assign clkphase1 = r_clkphase1;
    assign clk_en    = r_clk_en;
    assign tx_pause  = r_tx_pause;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_mio_clkseq.sv
// Bench for mio_clkseq: directed sequences with literal timing expectations, plus a
// timeline model (elapsed cycles since the request) compared against the outputs every cycle.
module tb_mio_clkseq;

    localparam int HOLD    = 4;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        nreset;
    logic        clkchange;
    logic [7:0]  clkdiv_in;
    logic [15:0] clkphase0_in;
    logic [15:0] clkphase1_in;
    logic        tx_en;
    logic        tx_empty;
    logic        tx_idle;
    logic        timeout_clr;
    logic [7:0]  clkdiv;
    logic [15:0] clkphase0;
    logic [15:0] clkphase1;
    logic        clk_en;
    logic        tx_pause;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mio_clkseq #(
        .DEF_CLK (7),
        .HOLD    (HOLD),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT),
        .CW      (16)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .clkchange    (clkchange),
        .clkdiv_in    (clkdiv_in),
        .clkphase0_in (clkphase0_in),
        .clkphase1_in (clkphase1_in),
        .tx_en        (tx_en),
        .tx_empty     (tx_empty),
        .tx_idle      (tx_idle),
        .timeout_clr  (timeout_clr),
        .clkdiv       (clkdiv),
        .clkphase0    (clkphase0),
        .clkphase1    (clkphase1),
        .clk_en       (clk_en),
        .tx_pause     (tx_pause),
        .busy         (busy),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A request is tracked by cycles elapsed since DRAIN began (m_t) and the drain
    // length once known (m_dlen, 0 while still draining). After the drain come
    // HOLD gated cycles, one gated load cycle, then SETTLE cycles.
    bit          m_seq;
    int          m_t;
    int          m_dlen;
    bit          m_pend;
    bit          m_to;
    logic [7:0]  m_sh_div, m_act_div;
    logic [15:0] m_sh_p0, m_sh_p1, m_act_p0, m_act_p1;
    logic        e_clk_en, e_pause, e_busy, e_to;
    logic [7:0]  e_div;
    logic [15:0] e_p0, e_p1;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_seq = 0; m_t = 0; m_dlen = 0; m_pend = 0; m_to = 0;
            m_sh_div = 8'h07; m_act_div = 8'h07;
            m_sh_p0 = 16'h0400; m_act_p0 = 16'h0400;
            m_sh_p1 = 16'h0602; m_act_p1 = 16'h0602;
            e_clk_en = 1; e_pause = 0; e_busy = 0; e_to = 0;
            e_div = 8'h07; e_p0 = 16'h0400; e_p1 = 16'h0602;
        end else begin : mstep
            bit draining, gated, load_now, settle_done, to_set;
            int u;
            draining    = m_seq && (m_dlen == 0);
            u           = m_t - m_dlen;
            gated       = m_seq && !draining && (u <= HOLD);
            load_now    = gated && (u == HOLD);
            settle_done = m_seq && !draining && (u == HOLD + SETTLE);
            to_set      = 0;
            // outputs after this edge reflect the cycle that just ended
            e_clk_en = !gated;
            e_pause  = m_seq;
            e_busy   = m_seq;
            e_div    = m_act_div;
            e_p0     = m_act_p0;
            e_p1     = m_act_p1;
            if (load_now) begin
                m_act_div = m_sh_div; m_act_p0 = m_sh_p0; m_act_p1 = m_sh_p1;
                m_pend = 0;
            end
            if (clkchange) begin
                m_sh_div = clkdiv_in; m_sh_p0 = clkphase0_in; m_sh_p1 = clkphase1_in;
                if (m_seq) m_pend = 1;
            end
            if (draining) begin
                if ((tx_empty && tx_idle) || !tx_en) begin
                    m_dlen = m_t + 1;
                end else if (m_t == TIMEOUT - 1) begin
                    m_dlen = m_t + 1;
                    to_set = 1;
                end
            end
            m_to = to_set ? 1'b1 : (timeout_clr ? 1'b0 : m_to);
            e_to = m_to;
            if (!m_seq) begin
                if (clkchange) begin m_seq = 1; m_t = 0; m_dlen = 0; end
            end else if (settle_done) begin
                if (m_pend) begin m_t = 0; m_dlen = 0; end
                else m_seq = 0;
            end else begin
                m_t++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && nreset) begin
            check("cyc clk_en",    {31'd0, clk_en},   {31'd0, e_clk_en});
            check("cyc tx_pause",  {31'd0, tx_pause}, {31'd0, e_pause});
            check("cyc busy",      {31'd0, busy},     {31'd0, e_busy});
            check("cyc timeout",   {31'd0, timeout},  {31'd0, e_to});
            check("cyc clkdiv",    {24'd0, clkdiv},   {24'd0, e_div});
            check("cyc clkphase0", {16'd0, clkphase0}, {16'd0, e_p0});
            check("cyc clkphase1", {16'd0, clkphase1}, {16'd0, e_p1});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request presented for exactly one edge (edge 0); returns just after edge 0.
    task automatic request(input logic [7:0] div);
        clkchange    = 1'b1;
        clkdiv_in    = div;
        clkphase0_in = {div, 8'h01};
        clkphase1_in = {8'h02, div};
        step();
        clkchange = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("wait_idle busy", {31'd0, busy}, 32'd0);
        step();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        nreset = 1'b1; clkchange = 1'b0; clkdiv_in = 8'h00;
        clkphase0_in = 16'h0000; clkphase1_in = 16'h0000;
        tx_en = 1'b1; tx_empty = 1'b1; tx_idle = 1'b1; timeout_clr = 1'b0;

        #2 nreset = 1'b0;
        #1;
        check("rst clkdiv",    {24'd0, clkdiv},    32'h07);
        check("rst clkphase0", {16'd0, clkphase0}, 32'h0400);
        check("rst clkphase1", {16'd0, clkphase1}, 32'h0602);
        check("rst clk_en",    {31'd0, clk_en},    32'd1);
        check("rst busy",      {31'd0, busy},      32'd0);
        check("rst tx_pause",  {31'd0, tx_pause},  32'd0);
        check("rst timeout",   {31'd0, timeout},   32'd0);
        #20 nreset = 1'b1;
        chk_en = 1'b1;
        step();

        // basic sequence to divider 3
        request(8'd3);
        for (int k = 1; k <= 23; k++) begin
            step();
            check($sformatf("seq clk_en e%0d", k), {31'd0, clk_en}, (k >= 2 && k <= 6) ? 32'd0 : 32'd1);
            check($sformatf("seq clkdiv e%0d", k), {24'd0, clkdiv}, (k >= 7) ? 32'd3 : 32'd7);
            check($sformatf("seq busy e%0d", k),   {31'd0, busy},   (k <= 22) ? 32'd1 : 32'd0);
            if (k == 7) check("seq clkphase0 e7", {16'd0, clkphase0}, 32'h0301);
        end
        wait_idle();

        // drain stuck: forced exit after TIMEOUT cycles
        tx_empty = 1'b0;
        request(8'd5);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("to timeout e%0d", k), {31'd0, timeout}, (k >= 8) ? 32'd1 : 32'd0);
            check($sformatf("to clk_en e%0d", k),  {31'd0, clk_en},  (k <= 8) ? 32'd1 : 32'd0);
        end
        tx_empty = 1'b1;
        wait_idle();
        check("to sticky", {31'd0, timeout}, 32'd1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("to cleared", {31'd0, timeout}, 32'd0);

        // timeout set and timeout_clr on the same edge: set wins
        tx_empty = 1'b0;
        request(8'd6);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) begin
                check("to2 before", {31'd0, timeout}, 32'd0);
                timeout_clr = 1'b1;
            end
            if (k == 8) begin
                check("to2 set wins", {31'd0, timeout}, 32'd1);
                timeout_clr = 1'b0;
            end
        end
        tx_empty = 1'b1;
        wait_idle();
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;

        // drain released after 5 cycles
        tx_empty = 1'b0;
        request(8'd4);
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("rel clk_en e%0d", k), {31'd0, clk_en}, (k <= 5) ? 32'd1 : 32'd0);
            check($sformatf("rel timeout e%0d", k), {31'd0, timeout}, 32'd0);
            if (k == 4) tx_empty = 1'b1;
        end
        wait_idle();

        // tx disabled: drain exits at once
        tx_en = 1'b0; tx_empty = 1'b0;
        request(8'd8);
        step();
        check("txen e1 clk_en", {31'd0, clk_en}, 32'd1);
        step();
        check("txen e2 clk_en", {31'd0, clk_en}, 32'd0);
        tx_en = 1'b1; tx_empty = 1'b1;
        wait_idle();
        check("txen clkdiv", {24'd0, clkdiv}, 32'd8);

        // second request during SETTLE re-enters DRAIN without going idle
        request(8'd3);
        for (int k = 1; k <= 45; k++) begin
            step();
            check($sformatf("pend busy e%0d", k), {31'd0, busy}, (k <= 44) ? 32'd1 : 32'd0);
            check($sformatf("pend clkdiv e%0d", k), {24'd0, clkdiv},
                  (k < 7) ? 32'd8 : ((k < 29) ? 32'd3 : 32'd9));
            check($sformatf("pend clk_en e%0d", k), {31'd0, clk_en},
                  ((k >= 2 && k <= 6) || (k >= 24 && k <= 28)) ? 32'd0 : 32'd1);
            clkchange = (k == 10);
            if (k == 10) begin
                clkdiv_in    = 8'd9;
                clkphase0_in = 16'h0901;
                clkphase1_in = 16'h0209;
            end
        end
        check("pend clkphase1", {16'd0, clkphase1}, 32'h0209);
        wait_idle();

        // reset asserted during STOP
        request(8'h20);
        step(); step(); step();
        nreset = 1'b0;
        #1;
        check("midrst clk_en",   {31'd0, clk_en},    32'd1);
        check("midrst tx_pause", {31'd0, tx_pause},  32'd0);
        check("midrst busy",     {31'd0, busy},      32'd0);
        check("midrst clkdiv",   {24'd0, clkdiv},    32'h07);
        check("midrst clkph0",   {16'd0, clkphase0}, 32'h0400);
        @(negedge clk);
        #1 nreset = 1'b1;
        step();
        request(8'd3);
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k == 6)  check("post clk_en e6", {31'd0, clk_en}, 32'd0);
            if (k == 6)  check("post clkdiv e6", {24'd0, clkdiv}, 32'h07);
            if (k == 7)  check("post clkdiv e7", {24'd0, clkdiv}, 32'd3);
            if (k == 23) check("post busy e23",  {31'd0, busy},   32'd0);
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
